sw_conditioner: RTL and testbench
=================================

Name: sw_conditioner

Overview:
Input conditioning stage directly upstream of the LED pattern block; it produces that block's i_sw bus from raw board switches. Each switch bit is synchronised into the clock domain, debounced by a per-bit stability counter, and published as a clean level plus single-cycle rise/fall pulses. Downstream logic sees only glitch-free, clock-aligned switch levels.

Parameters:
N_SW, 4, number of switch bits conditioned.
CNT_WIDTH, 20, width of each per-bit stability counter.
DEB_COUNT, 500000, consecutive stable cycles required to accept a new level; legal range 1 .. 2^CNT_WIDTH-1.
RESET_VAL, 4'b0000, value (N_SW bits) loaded into the synchronisers and o_sw during reset.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
i_reset  input  1  asynchronous, active-low reset (0 = reset asserted).
i_sw  input  N_SW  raw, asynchronous, bouncing switch inputs.
o_sw  output  N_SW  debounced switch levels; feeds the LED block's i_sw.
o_rise  output  N_SW  one-cycle pulse per bit when o_sw bit goes 0->1.
o_fall  output  N_SW  one-cycle pulse per bit when o_sw bit goes 1->0.
o_change  output  1  OR of all o_rise and o_fall bits, same cycle.

Behaviour:
- Reset (i_reset=0, asynchronous assert, synchronous-to-clock deassert): sync1=sync2=RESET_VAL, o_sw=RESET_VAL, all counters=0, o_rise=o_fall=0, o_change=0. Reset mid-debounce discards partial counts.
- Per bit, every rising edge: sync1<=i_sw[b]; sync2<=sync1.
- If sync2 != o_sw[b]: if cnt==DEB_COUNT-1 then o_sw[b]<=sync2, cnt<=0, pulse o_rise[b] (if sync2=1) or o_fall[b] (if sync2=0); else cnt<=cnt+1.
- If sync2 == o_sw[b]: cnt<=0 (any bounce back restarts the count).
- Latency: a clean level change sampled into sync1 at edge k appears on o_sw at edge k+DEB_COUNT+1; o_rise/o_fall are high for exactly that one cycle.
- Pulses are registered; default 0 every cycle unless set as above. o_rise[b] and o_fall[b] are never high simultaneously.
- Bits are fully independent; simultaneous changes on several bits each pulse in their own accept cycle; o_change is combinational OR of registered pulses.
- Counter never exceeds DEB_COUNT-1; no wrap-around possible.
- A pulse shorter than DEB_COUNT cycles at sync2 never reaches o_sw.
- DEB_COUNT=1: accepts a level after a single cycle at sync2 (pure 2-FF synchroniser plus edge detect).

Decomposition:
- Shared package sw_conditioner_pkg: default N_SW, CNT_WIDTH, DEB_COUNT constants; simulation override DEB_COUNT_SIM=4.
- One sub-module sw_debounce_bit (sync chain, counter, level register, rise/fall pulse for one bit, RESET_VAL bit as parameter); top instantiates N_SW copies in a generate loop and builds o_change.

Test Plan:
- Reset: i_reset=0 with i_sw=4'b1111, RESET_VAL=0 -> o_sw=4'b0000, o_rise=o_fall=0 while reset held and first 2 cycles after release.
- Clean step (DEB_COUNT=4): i_sw 0000->1001 sampled at edge k -> o_sw=1001 at edge k+5; o_rise=1001 and o_change=1 for exactly one cycle; o_fall=0.
- Bounce reject: i_sw[0] toggles 0,1,0,1 each 2 cycles then settles 1 -> o_sw[0] rises only 5 edges after final settle; exactly one o_rise[0] pulse.
- Glitch: i_sw[3] low for 3 cycles while o_sw[3]=1 -> o_sw[3] stays 1, no o_fall pulse.
- Independent bits: i_sw[2:1] 00->01 and i_sw[0] 1->0 on the same edge -> o_rise[1] and o_fall[0] pulse in the same cycle, o_change=1 once.
- Reset mid-operation: assert i_reset 2 cycles into a pending change -> o_sw returns to RESET_VAL immediately; after release the change needs full DEB_COUNT+1 edges again.

Source files
------------

// File: rtl/sw_conditioner_pkg.sv
// Shared defaults for the switch conditioning slice: board-level debounce
// constants plus the short debounce length used when simulating.
package sw_conditioner_pkg;

    localparam int unsigned N_SW_DEF      = 4;
    localparam int unsigned CNT_WIDTH_DEF = 20;
    localparam int unsigned DEB_COUNT_DEF = 500000;
    localparam int unsigned DEB_COUNT_SIM = 4;

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-FF synchroniser, stability counter, accepted level and
// registered single-cycle rise/fall pulses on each accepted transition.
module sw_debounce_bit
    import sw_conditioner_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int unsigned DEB_COUNT = DEB_COUNT_DEF,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEB_COUNT - 1);

    logic                 sync1;
    logic                 sync2;
    logic [CNT_WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
            level <= RESET_VAL;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            // Count only while the synchronised input disagrees with the
            // accepted level; any agreement restarts the stability window.
            if (sync2 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync2;
                    cnt   <= '0;
                    rise  <= sync2;
                    fall  <= ~sync2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sw_conditioner.sv
// Conditions raw board switches into clean levels plus edge pulses for the
// LED pattern block; every bit is debounced independently.
module sw_conditioner
    import sw_conditioner_pkg::*;
#(
    parameter int unsigned         N_SW      = N_SW_DEF,
    parameter int unsigned         CNT_WIDTH = CNT_WIDTH_DEF,
    parameter int unsigned         DEB_COUNT = DEB_COUNT_DEF,
    parameter logic [N_SW-1:0]     RESET_VAL = '0
) (
    input  logic            clock,
    input  logic            i_reset,
    input  logic [N_SW-1:0] i_sw,
    output logic [N_SW-1:0] o_sw,
    output logic [N_SW-1:0] o_rise,
    output logic [N_SW-1:0] o_fall,
    output logic            o_change
);

    for (genvar b = 0; b < N_SW; b++) begin : g_bit
        sw_debounce_bit #(
            .CNT_WIDTH (CNT_WIDTH),
            .DEB_COUNT (DEB_COUNT),
            .RESET_VAL (RESET_VAL[b])
        ) u_bit (
            .clk    (clock),
            .rst_n  (i_reset),
            .sw_raw (i_sw[b]),
            .level  (o_sw[b]),
            .rise   (o_rise[b]),
            .fall   (o_fall[b])
        );
    end

    always_comb begin
        o_change = |(o_rise | o_fall);
    end

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: directed scenarios plus random switch activity,
// checked against a sliding-window reference model of the debounce rule.
module tb_sw_conditioner;
    import sw_conditioner_pkg::*;

    localparam int             NSW = 4;
    localparam int             DEB = DEB_COUNT_SIM;
    localparam logic [NSW-1:0] RV  = 4'b0000;

    logic           clock   = 1'b0;
    logic           i_reset = 1'b0;
    logic [NSW-1:0] i_sw    = '0;
    logic [NSW-1:0] o_sw;
    logic [NSW-1:0] o_rise;
    logic [NSW-1:0] o_fall;
    logic           o_change;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    sw_conditioner #(
        .N_SW      (NSW),
        .CNT_WIDTH (20),
        .DEB_COUNT (DEB),
        .RESET_VAL (RV)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_sw     (i_sw),
        .o_sw     (o_sw),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_change (o_change)
    );

    // Reference model: hist[t] is the synchronised value seen at edge t
    // (two edges of pipeline delay). A bit flips at edge t when the DEB
    // most recent seen values, all since its last flip, differ from it.
    logic [NSW-1:0] hist[$];
    logic [NSW-1:0] exp_sw, exp_rise, exp_fall;
    int             edge_no;
    int             start[NSW];
    bit             m_ok;

    always @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            hist.delete();
            hist.push_back(RV);
            hist.push_back(RV);
            exp_sw   = RV;
            exp_rise = '0;
            exp_fall = '0;
            edge_no  = 0;
            for (int b = 0; b < NSW; b++) start[b] = 0;
        end else begin
            exp_rise = '0;
            exp_fall = '0;
            for (int b = 0; b < NSW; b++) begin
                m_ok = (edge_no + 1 >= start[b] + DEB);
                for (int j = 0; j < DEB && m_ok; j++)
                    if (hist[edge_no - j][b] == exp_sw[b]) m_ok = 0;
                if (m_ok) begin
                    exp_sw[b]   = ~exp_sw[b];
                    exp_rise[b] = exp_sw[b];
                    exp_fall[b] = ~exp_sw[b];
                    start[b]    = edge_no + 1;
                end
            end
            hist.push_back(i_sw);
            edge_no++;
        end
    end

    task automatic settle(input logic [NSW-1:0] v);
        i_sw = v;
        repeat (DEB + 4) @(negedge clock);
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_sw    = 4'b1111;
        repeat (3) @(negedge clock);
        checks++;
        if (o_sw !== 4'b0000 || o_rise !== 4'b0000 || o_fall !== 4'b0000 || o_change !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: o_sw=%b rise=%b fall=%b change=%b, required 0000/0000/0000/0",
                     o_sw, o_rise, o_fall, o_change);
        end
        i_reset = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            @(negedge clock);
            checks++;
            if (o_sw !== 4'b0000 || o_rise !== 4'b0000 || o_fall !== 4'b0000 || o_change !== 1'b0) begin
                errors++;
                $display("FAIL reset_release cycle %0d: o_sw=%b rise=%b fall=%b change=%b, required all 0",
                         n, o_sw, o_rise, o_fall, o_change);
            end
        end
        i_sw = 4'b0000;
        repeat (8) begin
            @(negedge clock);
            checks++;
            if (o_sw !== exp_sw || o_rise !== exp_rise || o_fall !== exp_fall) begin
                errors++;
                $display("FAIL reset_after: o_sw=%b rise=%b fall=%b, required %b/%b/%b",
                         o_sw, o_rise, o_fall, exp_sw, exp_rise, exp_fall);
            end
        end
    endtask

    task automatic test_clean_step();
        logic [NSW-1:0] want_lvl, want_rise;
        settle(4'b0000);
        i_sw = 4'b1001;
        for (int n = 1; n <= DEB + 3; n++) begin
            @(negedge clock);
            want_lvl  = (n >= DEB + 2) ? 4'b1001 : 4'b0000;
            want_rise = (n == DEB + 2) ? 4'b1001 : 4'b0000;
            checks++;
            if (o_sw !== want_lvl) begin
                errors++;
                $display("FAIL clean_level cycle %0d: o_sw=%b, required %b", n, o_sw, want_lvl);
            end
            checks++;
            if (o_rise !== want_rise || o_fall !== 4'b0000 || o_change !== (n == DEB + 2)) begin
                errors++;
                $display("FAIL clean_pulse cycle %0d: rise=%b fall=%b change=%b, required %b/0000/%0d",
                         n, o_rise, o_fall, o_change, want_rise, (n == DEB + 2));
            end
        end
    endtask

    task automatic test_bounce();
        int rises   = 0;
        int rise_at = -1;
        logic [NSW-1:0] phases;
        settle(4'b0000);
        phases = 4'b0101;
        for (int p = 0; p < 4; p++) begin
            i_sw[0] = phases[p];
            repeat (2) begin
                @(negedge clock);
                if (o_rise[0]) rises++;
                checks++;
                if (o_sw !== exp_sw) begin
                    errors++;
                    $display("FAIL bounce_level: o_sw=%b, required %b", o_sw, exp_sw);
                end
            end
        end
        i_sw[0] = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (o_rise[0]) begin
                rises++;
                if (rise_at < 0) rise_at = n;
            end
        end
        checks++;
        if (rises !== 1) begin
            errors++;
            $display("FAIL bounce_pulse_count: rises=%0d, required 1", rises);
        end
        checks++;
        if (rise_at !== DEB + 2) begin
            errors++;
            $display("FAIL bounce_latency: rise at cycle %0d, required %0d", rise_at, DEB + 2);
        end
    endtask

    task automatic test_glitch();
        int falls = 0;
        int lows  = 0;
        settle(4'b1000);
        i_sw = 4'b0000;
        for (int n = 1; n <= 15; n++) begin
            if (n == 4) i_sw = 4'b1000;
            @(negedge clock);
            if (o_fall[3]) falls++;
            if (!o_sw[3]) lows++;
        end
        checks++;
        if (falls !== 0 || lows !== 0) begin
            errors++;
            $display("FAIL glitch_reject: falls=%0d low_cycles=%0d, required 0/0", falls, lows);
        end
        checks++;
        if (o_sw !== 4'b1000) begin
            errors++;
            $display("FAIL glitch_level: o_sw=%b, required 1000", o_sw);
        end
    endtask

    task automatic test_independent();
        int changes = 0;
        logic [NSW-1:0] r_at = '0, f_at = '0;
        settle(4'b0001);
        i_sw = 4'b0010;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clock);
            if (o_change) changes++;
            if (n == DEB + 2) begin
                r_at = o_rise;
                f_at = o_fall;
            end
        end
        checks++;
        if (r_at !== 4'b0010 || f_at !== 4'b0001) begin
            errors++;
            $display("FAIL indep_pulses: rise=%b fall=%b, required 0010/0001", r_at, f_at);
        end
        checks++;
        if (changes !== 1) begin
            errors++;
            $display("FAIL indep_change_count: changes=%0d, required 1", changes);
        end
        checks++;
        if (o_sw !== 4'b0010) begin
            errors++;
            $display("FAIL indep_level: o_sw=%b, required 0010", o_sw);
        end
    endtask

    task automatic test_reset_mid();
        logic [NSW-1:0] want;
        settle(4'b0110);
        i_sw = 4'b1001;
        repeat (2) @(negedge clock);
        #2 i_reset = 1'b0;
        #1;
        checks++;
        if (o_sw !== RV || o_rise !== 4'b0000 || o_fall !== 4'b0000 || o_sw !== exp_sw) begin
            errors++;
            $display("FAIL reset_mid_async: o_sw=%b rise=%b fall=%b, required %b/0000/0000",
                     o_sw, o_rise, o_fall, RV);
        end
        repeat (2) @(negedge clock);
        i_reset = 1'b1;
        for (int n = 1; n <= DEB + 4; n++) begin
            @(negedge clock);
            want = (n >= DEB + 2) ? 4'b1001 : 4'b0000;
            checks++;
            if (o_sw !== want) begin
                errors++;
                $display("FAIL reset_mid_restart cycle %0d: o_sw=%b, required %b", n, o_sw, want);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < NSW; b++)
                if ($urandom_range(0, 5) == 0) i_sw[b] = ~i_sw[b];
            @(negedge clock);
            checks++;
            if (o_sw !== exp_sw || o_rise !== exp_rise || o_fall !== exp_fall) begin
                errors++;
                $display("FAIL random cycle %0d: o_sw=%b rise=%b fall=%b, required %b/%b/%b",
                         n, o_sw, o_rise, o_fall, exp_sw, exp_rise, exp_fall);
            end
            checks++;
            if (o_change !== |(exp_rise | exp_fall) || (o_rise & o_fall) !== 4'b0000) begin
                errors++;
                $display("FAIL random_change cycle %0d: change=%b rise&fall=%b, required %b/0000",
                         n, o_change, o_rise & o_fall, |(exp_rise | exp_fall));
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_independent();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
